// File: rtl/mc_controller.sv
// Multicycle control unit for the ARM-subset processor.
// Holds the main FSM, ALU decoder, NZCV flag register and condition check.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   Instr, ALUFlags   - instruction register contents and combinational NZCV from the ALU
//   PCWrite, MemWrite, RegWrite, IRWrite - write enables (held low while reset is high)
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl - datapath muxes
module mc_controller #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb,
        StMemWr, StExecR, StExecI, StAluWb, StBranch
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  flags_q;
    logic        condex_q;

    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        cond_ok;
    logic        rd_pc;
    logic [1:0]  alu_dec;
    logic [1:0]  flagw;
    logic        fn, fz, fc, fv;
    logic        unused_instr;

    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign rd    = Instr[15:12];
    assign cond  = Instr[31:28];
    assign cmd   = funct[4:1];
    assign rd_pc = (rd == 4'd15);
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    assign {fn, fz, fc, fv} = flags_q;

    // Condition evaluation against the registered flags.
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = fz;
            4'b0001: cond_ok = ~fz;
            4'b0010: cond_ok = fc;
            4'b0011: cond_ok = ~fc;
            4'b0100: cond_ok = fn;
            4'b0101: cond_ok = ~fn;
            4'b0110: cond_ok = fv;
            4'b0111: cond_ok = ~fv;
            4'b1000: cond_ok = fc & ~fz;
            4'b1001: cond_ok = ~fc | fz;
            4'b1010: cond_ok = (fn == fv);
            4'b1011: cond_ok = (fn != fv);
            4'b1100: cond_ok = ~fz & (fn == fv);
            4'b1101: cond_ok = fz | (fn != fv);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // ALU decoder; C,V are only written by arithmetic ops.
    always_comb begin
        case (cmd)
            4'b0100: alu_dec = 2'b00;
            4'b0010: alu_dec = 2'b01;
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            default: alu_dec = 2'b00;
        endcase
        flagw[1] = funct[0];
        flagw[0] = funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Condition latch and flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            condex_q <= 1'b0;
            flags_q  <= FLAGS_RST;
        end else begin
            if (state_q == StDecode) begin
                condex_q <= cond_ok;
            end
            if (((state_q == StExecR) || (state_q == StExecI)) && condex_q) begin
                if (flagw[1]) flags_q[3:2] <= ALUFlags[3:2];
                if (flagw[0]) flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (op)
                    2'b01:   state_d = StMemAdr;
                    2'b00:   state_d = funct[5] ? StExecI : StExecR;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            default:  state_d = StFetch;
        endcase
    end

    // Output logic.
    always_comb begin
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StDecode: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StMemAdr: ALUSrcB = 2'b01;
            StMemRd:  AdrSrc  = 1'b1;
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = condex_q;
                PCWrite   = condex_q & rd_pc;
            end
            StMemWr: begin
                AdrSrc   = 1'b1;
                MemWrite = condex_q;
            end
            StExecR:  ALUControl = alu_dec;
            StExecI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
            end
            StAluWb: begin
                RegWrite = condex_q;
                PCWrite  = condex_q & rd_pc;
            end
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = condex_q;
            end
            default: ;
        endcase
        // Reset can land mid-instruction; no write may escape in that cycle.
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
        end
    end

    assign RegSrc = {op == 2'b01, op == 2'b10};
    assign ImmSrc = op;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: per-cycle vector table, expected control words
// queued when stimulus is driven and compared when the cycle's outputs settle.
module tb_mc_controller;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    mc_controller #(.FLAGS_RST(4'b0000)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {PCW,MW,RW,IRW, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUCtl}
    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [3:0]  flg;
        logic [16:0] exp;
        logic [16:0] mask;
    } vec_t;

    typedef struct {
        logic [16:0] exp;
        logic [16:0] mask;
        int          id;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [16:0] FULL = 17'h1FFFF;
    localparam logic [16:0] ENS  = 17'h1E000;

    localparam logic [31:0] ADD   = 32'hE0810002;
    localparam logic [31:0] ADDPC = 32'hE081F002;
    localparam logic [31:0] ADDI  = 32'hE2810005;
    localparam logic [31:0] ADDS  = 32'hE0910002;
    localparam logic [31:0] SUBS  = 32'hE0513001;
    localparam logic [31:0] SUBSN = 32'h10513001;
    localparam logic [31:0] ANDR  = 32'hE0010002;
    localparam logic [31:0] ANDS  = 32'hE0110002;
    localparam logic [31:0] ORR   = 32'hE1810002;
    localparam logic [31:0] BEQ   = 32'h0A000001;
    localparam logic [31:0] BNE   = 32'h1A000001;
    localparam logic [31:0] BCS   = 32'h2A000001;
    localparam logic [31:0] LDR   = 32'hE5912004;
    localparam logic [31:0] STR   = 32'hE5812004;
    localparam logic [31:0] UNDEF = 32'hEC000000;

    function automatic logic [16:0] cw(input logic [3:0] en, input logic adr,
                                       input logic [1:0] op, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] res,
                                       input logic [1:0] alu);
        logic [1:0] rs;
        rs = {op == 2'b01, op == 2'b10};
        return {en, adr, rs, sa, sb, res, op, alu};
    endfunction

    function automatic logic [16:0] cw_fetch(input logic [1:0] op);
        return cw(4'b1001, 1'b0, op, 2'b01, 2'b10, 2'b10, 2'b00);
    endfunction

    function automatic logic [16:0] cw_dec(input logic [1:0] op);
        return cw(4'b0000, 1'b0, op, 2'b01, 2'b10, 2'b10, 2'b00);
    endfunction

    task automatic v(input logic rst, input logic [31:0] ins, input logic [3:0] f,
                     input logic [16:0] e, input logic [16:0] m);
        vec_t t;
        t.rst = rst; t.instr = ins; t.flg = f; t.exp = e; t.mask = m;
        vecs.push_back(t);
    endtask

    // Data-processing: FETCH, DECODE, EXEC, ALUWB.
    task automatic dp(input logic [31:0] ins, input logic imm, input logic [1:0] alu,
                      input logic [3:0] f, input logic [3:0] wb_en);
        v(1'b0, ins, 4'h0, cw_fetch(2'b00), FULL);
        v(1'b0, ins, 4'h0, cw_dec(2'b00), FULL);
        v(1'b0, ins, f, cw(4'b0000, 1'b0, 2'b00, 2'b00, imm ? 2'b01 : 2'b00, 2'b00, alu), FULL);
        v(1'b0, ins, 4'h0, cw(wb_en, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), FULL);
    endtask

    task automatic br(input logic [31:0] ins, input logic taken);
        v(1'b0, ins, 4'h0, cw_fetch(2'b10), FULL);
        v(1'b0, ins, 4'h0, cw_dec(2'b10), FULL);
        v(1'b0, ins, 4'h0, cw({taken, 3'b000}, 1'b0, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00), FULL);
    endtask

    task automatic step(input logic rst, input logic [31:0] ins, input logic [3:0] f,
                        input logic [16:0] e, input logic [16:0] m, input int id);
        sb_t s;
        logic [16:0] act;
        @(negedge clk);
        reset = rst; Instr = ins; ALUFlags = f;
        s.exp = e; s.mask = m; s.id = id;
        sbq.push_back(s);
        #2;
        act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
               ResultSrc, ImmSrc, ALUControl};
        s = sbq.pop_front();
        tests++;
        if ((act & s.mask) !== (s.exp & s.mask)) begin
            fails++;
            $display("FAIL ctrl[%0d]: got %05h want %05h (mask %05h)", s.id, act, s.exp,
                     s.mask);
        end
    endtask

    initial begin
        reset = 1'b1; Instr = 32'h0; ALUFlags = 4'h0;

        // Reset held two cycles: only the enables are defined before the first edge.
        v(1'b1, 32'h0, 4'h0, 17'h0, ENS);
        v(1'b1, 32'h0, 4'h0, 17'h0, ENS);
        dp(ADD, 1'b0, 2'b00, 4'b0100, 4'b0010);   // S=0: flags must stay 0000
        br(BEQ, 1'b0);
        dp(SUBS, 1'b0, 2'b01, 4'b0110, 4'b0010);  // flags <= 0110
        br(BEQ, 1'b1);
        dp(SUBSN, 1'b0, 2'b01, 4'b0000, 4'b0000); // NE fails: no write, no flag update
        br(BEQ, 1'b1);
        br(BNE, 1'b0);
        dp(ADDPC, 1'b0, 2'b00, 4'b0000, 4'b1010);
        dp(ORR, 1'b0, 2'b11, 4'b0000, 4'b0010);
        dp(ANDR, 1'b0, 2'b10, 4'b0000, 4'b0010);
        dp(ADDI, 1'b1, 2'b00, 4'b0000, 4'b0010);
        // LDR: 5 cycles
        v(1'b0, LDR, 4'h0, cw_fetch(2'b01), FULL);
        v(1'b0, LDR, 4'h0, cw_dec(2'b01), FULL);
        v(1'b0, LDR, 4'h0, cw(4'b0000, 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00), FULL);
        v(1'b0, LDR, 4'h0, cw(4'b0000, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00), FULL);
        v(1'b0, LDR, 4'h0, cw(4'b0010, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00), FULL);
        // STR: 4 cycles
        v(1'b0, STR, 4'h0, cw_fetch(2'b01), FULL);
        v(1'b0, STR, 4'h0, cw_dec(2'b01), FULL);
        v(1'b0, STR, 4'h0, cw(4'b0000, 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00), FULL);
        v(1'b0, STR, 4'h0, cw(4'b0100, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00), FULL);
        // Undefined op: straight back to FETCH
        v(1'b0, UNDEF, 4'h0, cw_fetch(2'b11), FULL);
        v(1'b0, UNDEF, 4'h0, cw_dec(2'b11), FULL);
        v(1'b0, UNDEF, 4'h0, cw_fetch(2'b11), FULL);
        // STR with reset landing in MEMWR: strobe suppressed, flags cleared
        v(1'b0, STR, 4'h0, cw_dec(2'b01), FULL);
        v(1'b0, STR, 4'h0, cw(4'b0000, 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00), FULL);
        v(1'b1, STR, 4'h0, cw(4'b0000, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00), FULL);
        br(BEQ, 1'b0);
        // ANDS touches only N,Z; ADDS also writes C,V
        dp(ANDS, 1'b0, 2'b10, 4'b0011, 4'b0010);
        br(BCS, 1'b0);
        dp(ADDS, 1'b0, 2'b00, 4'b0011, 4'b0010);
        br(BCS, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].instr, vecs[i].flg, vecs[i].exp, vecs[i].mask, i);
        end

        // Hand-written: reset arriving in MEMWB kills RegWrite, then FETCH follows.
        step(1'b0, LDR, 4'h0, cw_fetch(2'b01), FULL, 1000);
        step(1'b0, LDR, 4'h0, cw_dec(2'b01), FULL, 1001);
        step(1'b0, LDR, 4'h0, cw(4'b0000, 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00), FULL, 1002);
        step(1'b0, LDR, 4'h0, cw(4'b0000, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00), FULL, 1003);
        step(1'b1, LDR, 4'h0, cw(4'b0000, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00), FULL, 1004);
        step(1'b0, LDR, 4'h0, cw_fetch(2'b01), FULL, 1005);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle control unit for the ARM-subset processor. It consumes the datapath's Instr and ALUFlags outputs and drives every datapath control input, plus MemWrite to data/instruction memory. It contains the main FSM, the ALU decoder, the condition-code flag register and condition evaluation.

Parameters:
FLAGS_RST, 4'b0000, reset value of the NZCV flag register (bit3=N, 2=Z, 1=C, 0=V).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
Instr  input  32  current instruction register contents
ALUFlags  input  4  combinational NZCV from the ALU
PCWrite  output  1  PC register enable
MemWrite  output  1  memory write strobe
RegWrite  output  1  register file write enable
IRWrite  output  1  instruction register enable
AdrSrc  output  1  0=PC, 1=Result
RegSrc  output  2  [0]: RA1=R15; [1]: RA2=Rd
ALUSrcA  output  2  00=A, 01=PC
ALUSrcB  output  2  00=WriteData, 01=ExtImm, 10=constant 4
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ImmSrc  output  2  equals Instr[27:26]
ALUControl  output  2  00=add, 01=sub, 10=and, 11=orr

Behaviour:
- Clock and reset are fixed: one clock; reset is synchronous and active-high; ports named clk and reset.
- Reset actions:
  - state<=FETCH, flags<=FLAGS_RST, CondExR<=0.
  - While reset is high, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0, whatever the state. This also covers reset arriving mid-instruction.
- Decode fields: Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12], Cond=Instr[31:28].
- Outputs are Moore functions of state, plus the combinational decode and CondExR gating below.
- RegSrc[0]=(Op==10). RegSrc[1]=(Op==01). ImmSrc=Op in all states.
- States, with non-default outputs and next state. Defaults are all 0.
  - FETCH: IRWrite, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=add, ResultSrc=10, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ALUControl=add, ResultSrc=10. Loads CondExR from condition evaluation against the current flags. Next by Op:
    - Op=01: MEMADR.
    - Op=00 and Funct[5]=0: EXECR.
    - Op=00 and Funct[5]=1: EXECI.
    - Op=10: BRANCH.
    - Op=11: FETCH (undefined instruction, no side effects).
  - MEMADR: ALUSrcA=00, ALUSrcB=01, add. Next: MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=CondExR, PCWrite=CondExR&(Rd==15). Next: FETCH.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=CondExR. Next: FETCH.
  - EXECR: ALUSrcA=00, ALUSrcB=00, ALUControl from decoder. Next: ALUWB.
  - EXECI: same as EXECR but ALUSrcB=01. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=CondExR, PCWrite=CondExR&(Rd==15). Next: FETCH.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, add, ResultSrc=10, PCWrite=CondExR. Next: FETCH.
- Latency: data-processing 4 cycles, LDR 5, STR 4, B 3.
- ALU decoder (EXECR/EXECI only), cmd=Funct[4:1]:
  - 0100 add, 0010 sub, 0000 and, 1100 orr, any other cmd add.
  - FlagW[1] (N,Z) = Funct[0]. FlagW[0] (C,V) = Funct[0] & (cmd is add or sub).
- Flag register update: at the end of EXECR/EXECI only, when CondExR=1.
  - N,Z <= ALUFlags[3:2] if FlagW[1].
  - C,V <= ALUFlags[1:0] if FlagW[0].
  - Because CondExR was latched in DECODE, an instruction's own flag update never changes its own write enables.
- Condition evaluation:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) =1; 1111 =0.
- Unlisted state encodings return to FETCH with all enables 0.

Test Plan:
- Hold reset 2 cycles → PCWrite=IRWrite=RegWrite=MemWrite=0. After release, first cycle is FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- Instr=0xE0810002 (ADD R0,R1,R2) → states FETCH,DECODE,EXECR,ALUWB. In EXECR: ALUSrcA=00, ALUSrcB=00, ALUControl=00. In ALUWB: RegWrite=1, PCWrite=0. Flags unchanged.
- Instr=0xE0513001 (SUBS R3,R1,R1) with ALUFlags=4'b0110 in EXECR → ALUControl=01, flags become 0110. Then Instr=0x0A000001 (BEQ) → BRANCH with PCWrite=1, 3 cycles.
- With flags Z=0, Instr=0x0A000001 → BRANCH asserts PCWrite=0.
- Instr=0xE5912004 (LDR) → MEMADR (ALUSrcB=01), MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1); 5 cycles total. Instr=0xE5812004 (STR) → MEMWR with MemWrite=1 and AdrSrc=1; 4 cycles total.
- Assert reset during MEMWR → MemWrite=0 in that cycle; next cycle is FETCH and flags are 0000.
